// File: rtl/lattice_sweep_ctrl_pkg.sv
// lattice_pkg: shared constants, FSM states and row-count helpers for the lattice sweep
package lattice_pkg;
  localparam int LANES = 32;
  localparam int LANE_SH = 5;
  localparam int ADDR_W = 11;
  typedef enum logic [2:0] {IDLE, INIT, WAIT_INIT, SWEEP, DRAIN, DONE} state_t;
  // Rows read at step s, including the carry row feeding lane 31's up-neighbour
  function automatic logic [6:0] rows_rd(input logic [10:0] s);
    logic [11:0] t;
    t = ({1'b0, s} + 12'd1) >> LANE_SH;
    return t[6:0] + 7'd1;
  endfunction
  function automatic logic [6:0] rows_wr(input logic [10:0] s);
    logic [10:0] t;
    t = s >> $clog2(LANES);
    return t[6:0] + 7'd1;
  endfunction
endpackage

// File: rtl/lattice_sweep_ctrl_if.sv
// lattice_sweep_ctrl_if: control/bank-port bundle between the sweep controller and its neighbours
interface lattice_sweep_ctrl_if #(parameter int ADDR_W = lattice_pkg::ADDR_W);
  logic start;
  logic [10:0] num_steps;
  logic init_start;
  logic init_done;
  logic [ADDR_W-1:0] rdaddr;
  logic rd_en;
  logic q_valid;
  logic [ADDR_W-1:0] wraddr;
  logic wren;
  logic [10:0] step_idx;
  logic terminal;
  logic busy;
  logic done;
  modport master(
    input start, num_steps, init_done,
    output init_start, rdaddr, rd_en, q_valid, wraddr, wren, step_idx, terminal, busy, done
  );
  modport slave(
    output start, num_steps, init_done,
    input init_start, rdaddr, rd_en, q_valid, wraddr, wren, step_idx, terminal, busy, done
  );
endinterface

// File: rtl/lattice_sweep_ctrl_addr_delay_line.sv
// addr_delay_line: DEPTH-stage shift register of {valid, writable, addr} with synchronous clear
module addr_delay_line #(
  parameter int DEPTH = 8,
  parameter int DW = 13
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic [DW-1:0] i_d,
  output logic          o_tap1_valid,
  output logic [DW-1:0] o_q
);
  logic [DEPTH-1:0][DW-1:0] r_sr;
  always_ff @(posedge clk)
    r_sr <= !nrst ? '0 : {r_sr[DEPTH-2:0], i_d};
  assign o_tap1_valid = r_sr[0][DW-1];
  assign o_q = r_sr[DEPTH-1];
endmodule

// File: rtl/lattice_sweep_ctrl.sv
// lattice_sweep_ctrl: drives bank init, backward per-step row reads and delayed result writes
module lattice_sweep_ctrl #(
  parameter int ADDR_W = lattice_pkg::ADDR_W,
  parameter int PIPE_LAT = 8
) (
  input logic clk,
  input logic nrst,
  lattice_sweep_ctrl_if.master bus
);
  import lattice_pkg::*;
  state_t r_state, w_next;
  logic [10:0] r_num, r_step;
  logic r_term;
  logic [6:0] r_cnt, w_rows_rd, w_rows_wr;
  logic w_last_row, w_last_drain;
  logic [ADDR_W+1:0] w_dl_in, w_dl_out;
  logic w_tap1_valid;
  assign w_rows_rd = rows_rd(r_step);
  assign w_rows_wr = rows_wr(r_step);
  assign w_last_row = r_cnt == w_rows_rd - 7'd1;
  assign w_last_drain = r_cnt == 7'(PIPE_LAT - 1);
  always_ff @(posedge clk)
    r_state <= !nrst ? IDLE : w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      w_next = bus.start ? INIT : IDLE;
      INIT:      w_next = WAIT_INIT;
      WAIT_INIT: w_next = bus.init_done ? SWEEP : WAIT_INIT;
      SWEEP:     w_next = w_last_row ? DRAIN : SWEEP;
      DRAIN:     w_next = !w_last_drain ? DRAIN : (r_step == '0 ? DONE : SWEEP);
      DONE:      w_next = IDLE;
      default:   w_next = IDLE;
    endcase
    bus.init_start = r_state == INIT;
    bus.rd_en = r_state == SWEEP;
    bus.rdaddr = r_state == SWEEP ? ADDR_W'(r_cnt) : '0;
    bus.busy = r_state != IDLE;
    bus.done = r_state == DONE;
    bus.step_idx = r_step;
    bus.terminal = r_term;
    bus.q_valid = w_tap1_valid;
    bus.wraddr = w_dl_out[ADDR_W-1:0];
    bus.wren = w_dl_out[ADDR_W+1] & w_dl_out[ADDR_W];
  end
  // One counter walks read rows in SWEEP and drain cycles in DRAIN
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_num <= '0;
      r_step <= '0;
      r_term <= 1'b0;
      r_cnt <= '0;
    end else begin
      if (r_state == IDLE && bus.start) r_num <= bus.num_steps;
      if (r_state == WAIT_INIT && bus.init_done) begin
        r_step <= r_num;
        r_term <= 1'b1;
      end
      if (r_state == DRAIN && w_last_drain && r_step != '0) begin
        r_step <= r_step - 11'd1;
        r_term <= 1'b0;
      end
      r_cnt <= (r_state == SWEEP && !w_last_row) || (r_state == DRAIN && !w_last_drain) ? r_cnt + 7'd1 : '0;
    end
  end
  assign w_dl_in = {r_state == SWEEP, r_cnt < w_rows_wr, ADDR_W'(r_cnt)};
  addr_delay_line #(.DEPTH(PIPE_LAT), .DW(ADDR_W + 2)) u_dl (
    .clk(clk),
    .nrst(nrst),
    .i_d(w_dl_in),
    .o_tap1_valid(w_tap1_valid),
    .o_q(w_dl_out)
  );
endmodule

// File: tb/tb_lattice_sweep_ctrl.sv
// tb_lattice_sweep_ctrl: scoreboard bench; stimulus queues expected reads/writes/pulses, a monitor pops and compares
module tb_lattice_sweep_ctrl;
  localparam int P = 8;
  typedef struct {int cyc; int addr; int step; int term;} ent_t;
  logic clk = 1'b0;
  logic nrst = 1'b0;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  int n_rd = 0;
  int n_wr = 0;
  bit done_seen = 1'b0;
  ent_t rd_q[$];
  ent_t wr_q[$];
  int qv_q[$];
  int done_q[$];
  int init_q[$];
  lattice_sweep_ctrl_if #(.ADDR_W(11)) bus();
  lattice_sweep_ctrl #(.ADDR_W(11), .PIPE_LAT(P)) dut (.clk(clk), .nrst(nrst), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic void check(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction
  always @(negedge clk) begin
    ent_t e;
    if (bus.init_start) begin
      if (init_q.size() == 0) check("init_start_unexpected", cyc, -1);
      else check("init_start_cycle", cyc, init_q.pop_front());
    end
    if (bus.rd_en) begin
      n_rd++;
      if (rd_q.size() == 0) check("rd_unexpected", cyc, -1);
      else begin
        e = rd_q.pop_front();
        check("rd_cycle", cyc, e.cyc);
        check("rdaddr", int'(bus.rdaddr), e.addr);
        check("step_idx", int'(bus.step_idx), e.step);
        check("terminal", int'(bus.terminal), e.term);
        check("busy_in_sweep", int'(bus.busy), 1);
      end
    end
    if (bus.q_valid) begin
      if (qv_q.size() == 0) check("q_valid_unexpected", cyc, -1);
      else check("q_valid_cycle", cyc, qv_q.pop_front());
    end
    if (bus.wren) begin
      n_wr++;
      if (wr_q.size() == 0) check("wren_unexpected", cyc, -1);
      else begin
        e = wr_q.pop_front();
        check("wr_cycle", cyc, e.cyc);
        check("wraddr", int'(bus.wraddr), e.addr);
      end
    end
    if (bus.done) begin
      done_seen = 1'b1;
      if (done_q.size() == 0) check("done_unexpected", cyc, -1);
      else check("done_cycle", cyc, done_q.pop_front());
    end
  end
  task automatic check_reset_outs();
    check("rst_rdaddr", int'(bus.rdaddr), 0);
    check("rst_wraddr", int'(bus.wraddr), 0);
    check("rst_wren", int'(bus.wren), 0);
    check("rst_rd_en", int'(bus.rd_en), 0);
    check("rst_q_valid", int'(bus.q_valid), 0);
    check("rst_init_start", int'(bus.init_start), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_step_idx", int'(bus.step_idx), 0);
    check("rst_terminal", int'(bus.terminal), 0);
  endtask
  task automatic run_sweep(input int n, input bit mid_start, input bit inject_rst, input int exp_rd, input int exp_wr);
    int t0, t, r, w, lim;
    n_rd = 0;
    n_wr = 0;
    done_seen = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.num_steps = 11'(n);
    t0 = cyc;
    init_q.push_back(t0 + 1);
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("busy_after_start", int'(bus.busy), 1);
    bus.init_done = 1'b1;
    @(posedge clk); #1;
    bus.init_done = 1'b0;
    repeat (1025) @(posedge clk);
    #1;
    bus.init_done = 1'b1;
    t = cyc + 1;
    for (int s = n; s >= 0; s--) begin
      r = (s + 1) / 32 + 1;
      w = s / 32 + 1;
      for (int k = 0; k < r; k++) begin
        rd_q.push_back('{t + k, k, s, (s == n) ? 1 : 0});
        qv_q.push_back(t + k + 1);
        if (k < w) wr_q.push_back('{t + k + P, k, 0, 0});
      end
      t += r + P;
    end
    done_q.push_back(t);
    @(posedge clk); #1;
    bus.init_done = 1'b0;
    if (inject_rst) begin
      repeat (3) @(posedge clk);
      #1;
      nrst = 1'b0;
      rd_q.delete();
      wr_q.delete();
      qv_q.delete();
      done_q.delete();
      repeat (12) begin
        @(posedge clk); #1;
        check_reset_outs();
      end
      nrst = 1'b1;
      return;
    end
    if (mid_start) begin
      repeat (20) @(posedge clk);
      #1;
      bus.start = 1'b1;
      bus.num_steps = 11'd5;
      bus.init_done = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      bus.init_done = 1'b0;
    end
    lim = cyc + 40000;
    while (!done_seen && cyc < lim) @(posedge clk);
    check("done_seen", int'(done_seen), 1);
    #1;
    check("busy_after_done", int'(bus.busy), 0);
    check("rd_q_empty", rd_q.size(), 0);
    check("wr_q_empty", wr_q.size(), 0);
    check("qv_q_empty", qv_q.size(), 0);
    check("read_count", n_rd, exp_rd);
    check("write_count", n_wr, exp_wr);
    rd_q.delete();
    wr_q.delete();
    qv_q.delete();
    done_q.delete();
  endtask
  initial begin
    bus.start = 1'b0;
    bus.num_steps = '0;
    bus.init_done = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      check_reset_outs();
      bus.start = 1'($urandom_range(0, 1));
      bus.init_done = 1'($urandom_range(0, 1));
      bus.num_steps = 11'($urandom_range(0, 1023));
    end
    @(posedge clk); #1;
    check_reset_outs();
    nrst = 1'b1;
    bus.start = 1'b0;
    bus.init_done = 1'b0;
    run_sweep(0, 1'b0, 1'b0, 1, 1);
    run_sweep(31, 1'b0, 1'b0, 33, 32);
    run_sweep(40, 1'b1, 1'b0, 51, 50);
    run_sweep(31, 1'b0, 1'b1, 0, 0);
    run_sweep(31, 1'b0, 1'b0, 33, 32);
    run_sweep(1023, 1'b0, 1'b0, 16928, 16896);
    repeat (4) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/lattice_sweep_ctrl.md
# lattice_sweep_ctrl

Control stage that sits directly upstream of the 32-lane value memory bank and drives its address and write ports for one American-put lattice run. It first triggers the bank's zero-initialisation, then sweeps the bank backwards one time step at a time, from the terminal step `num_steps` down to step 0. For each step it issues row reads and marks when read data is valid for the node-update datapath. It then issues the matching delayed writes of the datapath's results back to the same rows.

## Interface
Parameters:
- `ADDR_W`, 11: row address width of the memory bank.
- `PIPE_LAT`, 8: cycles from `rdaddr` issue to result data valid at the bank's write port. Includes the 1-cycle registered read. Legal values are 2..31.

Ports:
- `clk`  in  1  clock.
- `nrst`  in  1  reset, synchronous, active-low.
- `start`  in  1  pulse; begins a run. Ignored while `busy`.
- `num_steps`  in  11  terminal step index, 0..1023. Sampled on an accepted `start`.
- `init_start`  out  1  one-cycle pulse to the bank's `start_init`.
- `init_done`  in  1  pulse from the bank's `done_init`.
- `rdaddr`  out  ADDR_W  bank read row.
- `rd_en`  out  1  `rdaddr` carries a valid read this cycle.
- `q_valid`  out  1  bank `q` outputs hold valid row data; equals `rd_en` delayed 1 cycle.
- `wraddr`  out  ADDR_W  bank write row.
- `wren`  out  1  bank write enable.
- `step_idx`  out  11  time step currently being swept.
- `terminal`  out  1  high while `step_idx == num_steps`; the datapath writes payoff instead of the discounted expectation.
- `busy`  out  1  a run is in progress.
- `done`  out  1  one-cycle pulse when the run completes.

## Operation
- Each bank row holds 32 nodes (lanes). Step s has s+1 nodes.
- Rows read per step: R(s) = ((s+1)>>5)+1. This includes the carry row that supplies lane 31's up-neighbour.
- Rows written per step: W(s) = (s>>5)+1.
- State machine:
  - IDLE: on `start`, latch `num_steps` and go to INIT.
  - INIT: pulse `init_start` for 1 cycle, then go to WAIT_INIT.
  - WAIT_INIT: wait for `init_done`, then load `step_idx` = `num_steps` and go to SWEEP.
  - SWEEP: assert `rd_en`. `rdaddr` counts 0..R(s)-1, one row per cycle. After the last row, go to DRAIN.
  - DRAIN: hold for PIPE_LAT cycles.
    - If `step_idx` is 0, go to DONE.
    - Otherwise decrement `step_idx` and go to SWEEP.
  - DONE: pulse `done` for 1 cycle, then go to IDLE.
- Write path:
  - A PIPE_LAT-deep delay line carries {valid, addr, writable}.
  - writable = addr < W(s), evaluated at read time.
  - `wraddr` = delayed addr.
  - `wren` = delayed valid AND delayed writable.
  - The carry row is read but never written.
- `terminal` and `step_idx` are registered and change only on the SWEEP entry cycle.
- Width rules:
  - R and W are computed in 7 bits; the maximum is 33 rows at s = 1023.
  - Addresses are zero-extended to ADDR_W.
- `num_steps` = 0: exactly one sweep, at s = 0 with `terminal` = 1, R = 1, W = 1.
- An `init_done` seen outside WAIT_INIT is ignored.
- A `start` seen while `busy` is ignored and does not relatch `num_steps`.
- Reset, including mid-run:
  - State returns to IDLE and the delay line is flushed.
  - All outputs are 0 on the cycle after `nrst` is sampled low: `rdaddr`, `wraddr`, `wren`, `rd_en`, `q_valid`, `init_start`, `busy`, `done`, `step_idx`, `terminal`.
  - No `wren` may be issued after reset is sampled, including writes still in flight.

## Timing
- Accepted `start` at cycle 0 gives `init_start` = 1 and `busy` = 1 at cycle 1.
- `init_done` at cycle t gives the first `rd_en` with `rdaddr` = 0 at t+1.
- A read issued at cycle c produces `q_valid` at c+1 and its `wren`/`wraddr` at c+PIPE_LAT.
- Step period is R(s)+PIPE_LAT cycles. The first read of the next step follows one cycle after the last write of the current step, so no read-after-write hazard exists.
- `done` is asserted 1 cycle after the final DRAIN cycle. `busy` falls in the cycle after `done`.
- `busy` stays high continuously from cycle 1 through the `done` cycle.

## Structure
- Shared package `lattice_pkg` holds:
  - `LANES` = 32 and `LANE_SH` = 5.
  - `ADDR_W`.
  - The state enum {IDLE, INIT, WAIT_INIT, SWEEP, DRAIN, DONE}.
  - Row-count helper functions for R(s) and W(s).
- One sub-module, `addr_delay_line`: a parameterised PIPE_LAT shift register with synchronous clear, carrying {valid, writable, addr}. Used for the write path; `q_valid` is tapped at stage 1.

## Test plan
- Reset hold: drive `nrst` = 0 with random inputs → every output reads 0; no `init_start` and no `wren`.
- `num_steps` = 0, PIPE_LAT = 8:
  - `start` → `init_start` at cycle 1. The bench model returns `init_done` 1026 cycles later.
  - Exactly one read of row 0 with `terminal` = 1 follows.
  - One `wren` to row 0 occurs 8 cycles after that read, then `done` 1 cycle after DRAIN ends.
- `num_steps` = 31:
  - Step 31 reads rows 0 and 1 and writes row 0 only.
  - Steps 30..0 each read and write row 0 only.
  - 32 sweeps in total; 33 reads, 32 writes.
- `num_steps` = 1023, checked by scoreboard:
  - Step 1023 reads 33 rows and writes 32.
  - Total `wren` count equals the sum of W(s) for s = 0..1023, i.e. 16896.
  - No write ever has `wraddr` ≥ W(s).
- `start` pulsed mid-sweep with a different `num_steps` → ignored; the sweep sequence and `done` timing are unchanged.
- `nrst` asserted 3 cycles after a read with writes still in flight → no `wren` after reset is sampled. A fresh `start` then completes normally.
